popcount16_unary_gen: RTL
=========================

# popcount16_unary_gen

Sequential inverse of the 16-input popcount: accepts a 5-bit count C and regenerates a 16-bit unary word containing exactly min(C,16) ones. The word is emitted both as a backpressured bit-serial stream and as a parallel word. It sits at the other end of the popcount datapath. It feeds printed-neuron test harnesses and stochastic-style bitstream consumers, and it closes the loop for verifying approximate popcount units: generate, re-count, compare.

## Interface
- N, 16, unary word length (fixed; only 16 supported)
- CW, 5, count width = $clog2(N+1)
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cnt_valid  in  1  count offered
- cnt_ready  out  1  block idle, will accept count
- cnt_in  in  CW  requested count, 0..31 (values >16 clamp)
- spread  in  1  0 = thermometer, 1 = evenly spread (Bresenham); sampled at accept
- bit_valid  out  1  serial bit available
- bit_ready  in  1  consumer takes bit
- bit_out  out  1  current serial bit, index k = 0..15 in order
- bit_last  out  1  asserted with bit index 15
- word_valid  out  1  one-cycle pulse, word_out complete
- word_out  out  N  assembled word, bit k = k-th serial bit; held until next completion
- sat  out  1  last accepted cin exceeded 16; held until next accept
- busy  out  1  state != IDLE

## Operation
- States: IDLE, EMIT, DONE.
- IDLE: cnt_ready=1. On cnt_valid&&cnt_ready: C = (cnt_in>16)?16:cnt_in; sat = (cnt_in>16); latch spread; k=0, acc=0, shift register cleared; -> EMIT.
- EMIT: bit_valid=1; bit_out computed combinationally from k/acc, stable while stalled.
  - Thermometer: bit = (k < C).
  - Spread: s = acc + C (6-bit); bit = (s >= 16); acc_next = bit ? s-16 : s.
  - On bit_valid&&bit_ready: commit acc, word bit k <= bit, k++. If k==15 -> DONE.
- DONE: word_out <= assembled word, word_valid=1 for exactly one cycle; -> IDLE.
- The spread pattern has exactly C ones and acc returns to 0 after 16 steps. Any popcount mismatch is a design error.
- C=0 gives all zeros; C=16 gives all ones in both modes.
- cnt_in/spread changes outside the accept cycle are ignored.
- Reset mid-operation: immediate return to IDLE. bit_valid, word_valid, sat, busy, word_out, k, acc all go to 0. The in-flight count is discarded.

## Timing
- Reset values: cnt_ready=1, bit_valid=0, bit_out=0, bit_last=0, word_valid=0, word_out=0, sat=0, busy=0.
- Accept at edge t -> bit_valid=1 from cycle t+1.
- With bit_ready held high: 16 bit cycles, then word_valid in cycle t+17, and cnt_ready=1 in cycle t+18. Throughput is 1 count per 18 cycles.
- bit_ready low stalls EMIT indefinitely; bit_out/bit_last stay stable and no output change occurs.
- word_valid never coincides with bit_valid. cnt_ready=0 whenever busy=1.
- All outputs are registered or decoded from registered state only. There is no combinational path from cnt_* or bit_ready to any output except through the state registers.

## Structure
- Shared package popcount16_pkg:
  - constants N=16, CW=5, ACCW=6
  - state enum {IDLE, EMIT, DONE}
  - function clamp_count(cin) -> C.
- Sub-module popcount16_unary_step: combinational one-step generator.
  - Inputs: mode, k, acc, C. Outputs: bit, acc_next.
  - Reused by the bench as a reference model.
- Top holds the FSM, k counter (4-bit), acc register, C/mode latches, 16-bit shift/assembly register and output register.

## Test plan
- Reset released, cnt_in=5, spread=0, bit_ready=1 -> serial 1,1,1,1,1 then eleven 0s. word_out=0x001F, word_valid at accept+17, sat=0.
- cnt_in=5, spread=1 -> ones at k=3,6,9,12,15. word_out=0x9248. cnt_in=4, spread=1 -> 0x8888.
- cnt_in=0 and cnt_in=16, both modes -> 0x0000 / 0xFFFF. cnt_in=20 -> 0xFFFF, sat=1 until next accept.
- Random bit_ready toggling (50%), cnt_in=11, spread=1 -> bit_out stable across stalls, bit_last only on the 16th bit, and the stream matches the unstalled case.
- Async rst pulse at bit k=7 -> outputs zero within the reset cycle. The next accept with cnt_in=3, spread=0 yields 0x0007 cleanly.
- Sweep cnt_in 0..31 × both modes with random backpressure. Exact popcount(word_out) = min(cnt_in,16), and cnt_valid held high during busy causes no extra accepts.

Source files
------------

// File: rtl/popcount16_unary_gen_pkg.sv
// Shared constants, FSM state type and count clamping for the unary word generator.
package popcount16_pkg;

    localparam int N    = 16;
    localparam int CW   = 5;
    localparam int ACCW = 6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        DONE = 2'd2
    } state_t;

    // Requests above N saturate to N ones.
    function automatic logic [CW-1:0] clamp_count(input logic [CW-1:0] cin);
        return (cin > CW'(N)) ? CW'(N) : cin;
    endfunction

endpackage

// File: rtl/popcount16_unary_gen_if.sv
// Count request, serial bit stream and parallel word result of the unary generator.
interface popcount16_unary_gen_if;
    import popcount16_pkg::*;

    // Both streams use valid/ready: a transfer happens on a rising edge where
    // valid and ready are both high; a source holds valid and its payload
    // stable until that edge, and ready may toggle freely.
    logic          cnt_valid;
    logic          cnt_ready;
    logic [CW-1:0] cnt_in;
    logic          spread;
    logic          bit_valid;
    logic          bit_ready;
    logic          bit_out;
    logic          bit_last;
    logic          word_valid;
    logic [N-1:0]  word_out;
    logic          sat;
    logic          busy;

    modport slave (
        input  cnt_valid, cnt_in, spread, bit_ready,
        output cnt_ready, bit_valid, bit_out, bit_last, word_valid, word_out, sat, busy
    );

    modport master (
        output cnt_valid, cnt_in, spread, bit_ready,
        input  cnt_ready, bit_valid, bit_out, bit_last, word_valid, word_out, sat, busy
    );

endinterface

// File: rtl/popcount16_unary_gen_step.sv
// One step of unary generation: thermometer compare or Bresenham error accumulation.
module popcount16_unary_step
    import popcount16_pkg::*;
(
    input  logic            mode,
    input  logic [3:0]      k,
    input  logic [ACCW-1:0] acc,
    input  logic [CW-1:0]   c,
    output logic            step_bit,
    output logic [ACCW-1:0] acc_next
);

    logic [ACCW-1:0] s;

    always_comb begin
        s        = acc + ACCW'(c);
        step_bit = 1'b0;
        acc_next = acc;
        if (mode) begin
            // acc stays below N, so s fits in ACCW bits for any c <= N.
            step_bit = (s >= ACCW'(N));
            acc_next = step_bit ? (s - ACCW'(N)) : s;
        end else begin
            step_bit = ({1'b0, k} < c);
        end
    end

endmodule

// File: rtl/popcount16_unary_gen.sv
// Regenerates a 16-bit unary word with min(C,16) ones, streamed bit-serially and as a word.
module popcount16_unary_gen
    import popcount16_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    popcount16_unary_gen_if.slave bus,
    output state_t                state_dbg
);

    state_t          state;
    logic [3:0]      k;
    logic [ACCW-1:0] acc;
    logic [CW-1:0]   c_lat;
    logic            mode;
    logic [N-1:0]    asm_word;
    logic [N-1:0]    word_q;
    logic            sat_q;

    logic            step_bit;
    logic [ACCW-1:0] acc_next;

    popcount16_unary_step u_step (
        .mode     (mode),
        .k        (k),
        .acc      (acc),
        .c        (c_lat),
        .step_bit (step_bit),
        .acc_next (acc_next)
    );

    // Every output decodes from registers only, so a stalled bit stays put.
    assign bus.cnt_ready  = (state == IDLE);
    assign bus.bit_valid  = (state == EMIT);
    assign bus.bit_out    = (state == EMIT) && step_bit;
    assign bus.bit_last   = (state == EMIT) && (k == 4'd15);
    assign bus.word_valid = (state == DONE);
    assign bus.word_out   = word_q;
    assign bus.sat        = sat_q;
    assign bus.busy       = (state != IDLE);
    assign state_dbg      = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            k        <= '0;
            acc      <= '0;
            c_lat    <= '0;
            mode     <= 1'b0;
            asm_word <= '0;
            word_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cnt_valid) begin
                        c_lat    <= clamp_count(bus.cnt_in);
                        sat_q    <= (bus.cnt_in > CW'(N));
                        mode     <= bus.spread;
                        k        <= '0;
                        acc      <= '0;
                        asm_word <= '0;
                        state    <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.bit_ready) begin
                        // Shifting in at the top lands serial bit k at word bit k after 16 steps.
                        acc      <= acc_next;
                        asm_word <= {step_bit, asm_word[N-1:1]};
                        k        <= k + 4'd1;
                        if (k == 4'd15) begin
                            word_q <= {step_bit, asm_word[N-1:1]};
                            state  <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
